// File: rtl/data_memory_responder_if.sv
// ----------------------------------------------------------------------------
// data_memory_responder_if
//   Line-transfer bus between the data cache (initiator) and the off-chip
//   data memory model (responder).
//
//   Request side (initiator -> responder):
//     enable_i  request valid
//     write_i   1 = line write, 0 = line read
//     addr_i    byte address of the line
//     data_i    line data for writes
//   Response side (responder -> initiator):
//     ack_o     one-cycle completion pulse
//     data_o    line data returned by reads
//     busy_o    a transaction is in progress
//
//   The _i/_o suffixes are named from the responder's point of view.
// ----------------------------------------------------------------------------
interface data_memory_responder_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic                  enable_i;
    logic                  write_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [LINE_WIDTH-1:0] data_i;
    logic                  ack_o;
    logic [LINE_WIDTH-1:0] data_o;
    logic                  busy_o;

    modport master (
        output enable_i, write_i, addr_i, data_i,
        input  ack_o, data_o, busy_o
    );

    modport slave (
        input  enable_i, write_i, addr_i, data_i,
        output ack_o, data_o, busy_o
    );
endinterface

// File: rtl/data_memory_responder.sv
// ----------------------------------------------------------------------------
// data_memory_responder
//   Off-chip data memory model answering the data cache's line-transfer bus.
//   Accepts one line read or write at a time, performs the access after a
//   fixed latency and reports completion with a single-cycle ack.
//
//   Ports:
//     clk_i   clock, rising edge
//     rst_i   asynchronous, active-low reset
//     bus     slave side of data_memory_responder_if
//             (enable_i/write_i/addr_i/data_i in, ack_o/data_o/busy_o out)
//
//   Timing: a request accepted at edge E0 performs its access and raises
//   ack_o at edge E0+LATENCY-1; ack_o is high for exactly one cycle and is
//   followed by at least one IDLE cycle before the next acceptance.
// ----------------------------------------------------------------------------
module data_memory_responder #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int LATENCY    = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    data_memory_responder_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    // Counter only needs to reach LATENCY-2.
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);
    // With LATENCY=1 the access happens on the accepting edge itself.
    localparam bit DIRECT = (LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_write;
    logic [IDX_W-1:0]      r_idx;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic                  r_ack;
    logic                  r_busy;
    logic [LINE_WIDTH-1:0] r_rdata;

    // Line storage; deliberately never reset.
    logic [LINE_WIDTH-1:0] r_mem [DEPTH];

    logic [IDX_W-1:0]      w_idx_in;
    logic                  w_do_access;
    logic                  w_acc_write;
    logic [IDX_W-1:0]      w_acc_idx;
    logic [LINE_WIDTH-1:0] w_acc_data;

    // Byte offset and address bits above the array are don't-care.
    assign w_idx_in = bus.addr_i[OFF_W +: IDX_W];

    generate
        if (OFF_W + IDX_W < ADDR_WIDTH) begin : g_upper_unused
            logic w_unused_addr;
            assign w_unused_addr = ^{bus.addr_i[ADDR_WIDTH-1:OFF_W+IDX_W], bus.addr_i[OFF_W-1:0]};
        end else begin : g_lower_unused
            logic w_unused_addr;
            assign w_unused_addr = ^bus.addr_i[OFF_W-1:0];
        end
    endgenerate

    // Access edge: the last WAIT edge, or the accepting edge when DIRECT.
    // Gated with rst_i so a reset pulse can never commit a write.
    always_comb begin
        w_do_access = 1'b0;
        w_acc_write = r_write;
        w_acc_idx   = r_idx;
        w_acc_data  = r_wdata;
        if (DIRECT) begin
            w_do_access = rst_i && (r_state == S_IDLE) && bus.enable_i;
            w_acc_write = bus.write_i;
            w_acc_idx   = w_idx_in;
            w_acc_data  = bus.data_i;
        end else begin
            w_do_access = rst_i && (r_state == S_WAIT) && (r_cnt == CNT_LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_access && w_acc_write) begin
            r_mem[w_acc_idx] <= w_acc_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.enable_i) begin
                        r_write <= bus.write_i;
                        r_idx   <= w_idx_in;
                        r_wdata <= bus.data_i;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        if (DIRECT) begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                    end
                end
                S_ACK: begin
                    // enable_i is ignored here, guaranteeing an IDLE gap.
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Read data lands together with ack and holds until the next read.
            if (w_do_access && !w_acc_write) begin
                r_rdata <= r_mem[w_acc_idx];
            end
        end
    end

    assign bus.ack_o  = r_ack;
    assign bus.busy_o = r_busy;
    assign bus.data_o = r_rdata;

endmodule
